// File: rtl/asrv32_mem_arbiter.sv
// Two-port (fetch/data) round-robin arbiter onto one shared memory port.
// Registered FSM with per-access timeout that reports a bus error.
module asrv32_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ibus_req,
  input  logic [31:0] i_ibus_addr,
  output logic [31:0] o_ibus_rdata,
  output logic        o_ibus_ack,
  input  logic        i_dbus_req,
  input  logic [31:0] i_dbus_addr,
  input  logic [31:0] i_dbus_wdata,
  input  logic [3:0]  i_dbus_wr_mask,
  input  logic        i_dbus_wr_en,
  output logic [31:0] o_dbus_rdata,
  output logic        o_dbus_ack,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wr_mask,
  output logic        o_mem_wr_en,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_bus_err,
  output logic        o_err_is_data
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } state_t;

  localparam logic [9:0] TMO = 10'(TIMEOUT_CYCLES);

  state_t     state;
  logic       last_d;
  logic [9:0] cnt;
  logic       gnt_i;
  logic       gnt_d;
  logic       tmo;
  logic       on_d;

  // On a tie the requester not served last wins
  assign gnt_i = i_ibus_req & (~i_dbus_req | last_d);
  assign gnt_d = i_dbus_req & (~i_ibus_req | ~last_d);
  assign tmo   = (cnt + 10'd1) == TMO;
  assign on_d  = (state == BUSY_D);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      last_d        <= 1'b1;
      cnt           <= '0;
      o_ibus_rdata  <= '0;
      o_ibus_ack    <= 1'b0;
      o_dbus_rdata  <= '0;
      o_dbus_ack    <= 1'b0;
      o_mem_req     <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_mem_wr_mask <= '0;
      o_mem_wr_en   <= 1'b0;
      o_bus_err     <= 1'b0;
      o_err_is_data <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            gnt_i: begin
              state         <= BUSY_I;
              last_d        <= 1'b0;
              cnt           <= '0;
              o_mem_req     <= 1'b1;
              o_mem_addr    <= i_ibus_addr;
              o_mem_wdata   <= '0;
              o_mem_wr_mask <= 4'b0000;
              o_mem_wr_en   <= 1'b0;
            end
            gnt_d: begin
              state         <= BUSY_D;
              last_d        <= 1'b1;
              cnt           <= '0;
              o_mem_req     <= 1'b1;
              o_mem_addr    <= i_dbus_addr;
              o_mem_wdata   <= i_dbus_wdata;
              o_mem_wr_mask <= i_dbus_wr_mask;
              o_mem_wr_en   <= i_dbus_wr_en;
            end
            default: ;
          endcase
        end
        BUSY_I, BUSY_D: begin
          // An ack in the expiring cycle still completes normally
          if (i_mem_ack) begin
            state     <= RESP;
            o_mem_req <= 1'b0;
            if (on_d) begin
              o_dbus_rdata <= i_mem_rdata;
              o_dbus_ack   <= 1'b1;
            end else begin
              o_ibus_rdata <= i_mem_rdata;
              o_ibus_ack   <= 1'b1;
            end
          end else if (tmo) begin
            state         <= RESP;
            o_mem_req     <= 1'b0;
            o_bus_err     <= 1'b1;
            o_err_is_data <= on_d;
            if (on_d) begin
              o_dbus_rdata <= '0;
              o_dbus_ack   <= 1'b1;
            end else begin
              o_ibus_rdata <= '0;
              o_ibus_ack   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        RESP: begin
          state         <= IDLE;
          o_ibus_ack    <= 1'b0;
          o_dbus_ack    <= 1'b0;
          o_bus_err     <= 1'b0;
          o_err_is_data <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_asrv32_mem_arbiter.sv
// Bench for asrv32_mem_arbiter: directed vector table, reset corner
// sequence and randomized traffic against a transaction-level model.
module tb_asrv32_mem_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_ibus_req;
  logic [31:0] i_ibus_addr;
  logic [31:0] o_ibus_rdata;
  logic        o_ibus_ack;
  logic        i_dbus_req;
  logic [31:0] i_dbus_addr;
  logic [31:0] i_dbus_wdata;
  logic [3:0]  i_dbus_wr_mask;
  logic        i_dbus_wr_en;
  logic [31:0] o_dbus_rdata;
  logic        o_dbus_ack;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wr_mask;
  logic        o_mem_wr_en;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ack;
  logic        o_bus_err;
  logic        o_err_is_data;

  always #5 clk = ~clk;

  asrv32_mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk),
    .i_rst_n(i_rst_n),
    .i_ibus_req(i_ibus_req),
    .i_ibus_addr(i_ibus_addr),
    .o_ibus_rdata(o_ibus_rdata),
    .o_ibus_ack(o_ibus_ack),
    .i_dbus_req(i_dbus_req),
    .i_dbus_addr(i_dbus_addr),
    .i_dbus_wdata(i_dbus_wdata),
    .i_dbus_wr_mask(i_dbus_wr_mask),
    .i_dbus_wr_en(i_dbus_wr_en),
    .o_dbus_rdata(o_dbus_rdata),
    .o_dbus_ack(o_dbus_ack),
    .o_mem_req(o_mem_req),
    .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .o_mem_wr_mask(o_mem_wr_mask),
    .o_mem_wr_en(o_mem_wr_en),
    .i_mem_rdata(i_mem_rdata),
    .i_mem_ack(i_mem_ack),
    .o_bus_err(o_bus_err),
    .o_err_is_data(o_err_is_data)
  );

  typedef struct {
    bit          rst;
    bit          ri;
    bit          rd;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] dw;
    logic [3:0]  dm;
    bit          dwr;
    int          lat;
    logic [31:0] mrd;
    bit          exp_d;
    bit          exp_err;
  } vec_t;

  vec_t tbl[11];

  int n_chk = 0;
  int n_fail = 0;

  // Requester model: pending flags, their held fields, last winner
  bit          pend_i, pend_d;
  logic [31:0] ia, da, dw;
  logic [3:0]  dm;
  bit          dwr;
  logic [31:0] exp_ir, exp_dr;
  bit          lg;
  bit          rexp_d;
  int          rlat;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic raise_i(input logic [31:0] a);
    if (!pend_i) begin
      pend_i      = 1'b1;
      ia          = a;
      i_ibus_req  = 1'b1;
      i_ibus_addr = a;
    end
  endtask

  task automatic raise_d(input logic [31:0] a, input logic [31:0] w,
                         input logic [3:0] m, input bit wr);
    if (!pend_d) begin
      pend_d         = 1'b1;
      da             = a;
      dw             = w;
      dm             = m;
      dwr            = wr;
      i_dbus_req     = 1'b1;
      i_dbus_addr    = a;
      i_dbus_wdata   = w;
      i_dbus_wr_mask = m;
      i_dbus_wr_en   = wr;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_req"}, 32'(o_mem_req), 32'd0);
    check({tag, "_mem_addr"}, o_mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, o_mem_wdata, 32'd0);
    check({tag, "_ctl"}, 32'({o_mem_wr_mask, o_mem_wr_en, o_ibus_ack,
                             o_dbus_ack, o_bus_err, o_err_is_data}), 32'd0);
    check({tag, "_irdata"}, o_ibus_rdata, 32'd0);
    check({tag, "_drdata"}, o_dbus_rdata, 32'd0);
  endtask

  // Called at a negedge; outputs must clear without waiting for a clock
  task automatic do_reset(input bit keep);
    i_rst_n   = 1'b0;
    i_mem_ack = 1'b0;
    if (!keep) begin
      pend_i     = 1'b0;
      pend_d     = 1'b0;
      i_ibus_req = 1'b0;
      i_dbus_req = 1'b0;
    end
    #1;
    check_zero("async_rst");
    exp_ir = '0;
    exp_dr = '0;
    lg     = 1'b1;
    @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  task automatic idle_cycle();
    i_mem_ack   = 1'($urandom);
    i_mem_rdata = $urandom;
    @(negedge clk);
    check("idle_mem_req", 32'(o_mem_req), 32'd0);
    check("idle_acks", 32'({o_ibus_ack, o_dbus_ack, o_bus_err}), 32'd0);
    i_mem_ack = 1'b0;
  endtask

  // One access from grant edge to the idle cycle after the response
  task automatic run_txn(input bit exp_d, input bit exp_err, input int lat,
                         input logic [31:0] mrd, input bit mid);
    logic [31:0] ea, ew, er;
    logic [4:0]  ectl;
    int          n;
    n    = exp_err ? T : lat;
    ea   = exp_d ? da : ia;
    ew   = dw;
    ectl = exp_d ? {dm, dwr} : 5'b0;
    er   = exp_err ? 32'd0 : mrd;
    @(negedge clk);
    for (int k = 1; k <= n; k++) begin
      check("busy_mem_req", 32'(o_mem_req), 32'd1);
      check("busy_mem_addr", o_mem_addr, ea);
      if (exp_d) check("busy_mem_wdata", o_mem_wdata, ew);
      check("busy_mem_ctl", 32'({o_mem_wr_mask, o_mem_wr_en}), 32'(ectl));
      check("busy_acks", 32'({o_ibus_ack, o_dbus_ack, o_bus_err}), 32'd0);
      i_mem_ack   = (k == lat);
      i_mem_rdata = (k == lat) ? mrd : $urandom;
      if (!exp_d && !pend_d) begin
        i_dbus_addr    = $urandom;
        i_dbus_wdata   = $urandom;
        i_dbus_wr_mask = 4'($urandom);
        i_dbus_wr_en   = 1'($urandom);
      end
      if (exp_d && !pend_i) i_ibus_addr = $urandom;
      if (mid && $urandom_range(0, 3) == 0) begin
        if (exp_d) raise_i($urandom);
        else raise_d($urandom, $urandom, 4'($urandom), 1'($urandom));
      end
      @(negedge clk);
    end
    if (exp_d) exp_dr = er;
    else exp_ir = er;
    check("resp_acks", 32'({o_ibus_ack, o_dbus_ack}), exp_d ? 32'd1 : 32'd2);
    check("resp_irdata", o_ibus_rdata, exp_ir);
    check("resp_drdata", o_dbus_rdata, exp_dr);
    check("resp_bus_err", 32'(o_bus_err), 32'(exp_err));
    if (exp_err) check("resp_err_is_data", 32'(o_err_is_data), 32'(exp_d));
    check("resp_mem_req", 32'(o_mem_req), 32'd0);
    if (exp_d) begin
      pend_d     = 1'b0;
      i_dbus_req = 1'b0;
    end else begin
      pend_i     = 1'b0;
      i_ibus_req = 1'b0;
    end
    i_mem_ack   = 1'($urandom);
    i_mem_rdata = $urandom;
    lg          = exp_d;
    @(negedge clk);
    check("idle_mem_req", 32'(o_mem_req), 32'd0);
    check("idle_acks", 32'({o_ibus_ack, o_dbus_ack, o_bus_err}), 32'd0);
    check("hold_irdata", o_ibus_rdata, exp_ir);
    check("hold_drdata", o_dbus_rdata, exp_dr);
    i_mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1, 1, 1, 32'h200, 32'h100, 32'hDEADBEEF, 4'hF, 1, 2,
                32'h1111_0000, 0, 0};
    tbl[1]  = '{0, 1, 0, 32'h204, 0, 0, 0, 0, 1, 32'h2222_0000, 1, 0};
    tbl[2]  = '{0, 0, 1, 0, 32'h300, 0, 0, 0, 3, 32'h3333_0000, 0, 0};
    tbl[3]  = '{0, 1, 0, 32'h208, 0, 0, 0, 0, 1, 32'h4444_0000, 1, 0};
    tbl[4]  = '{1, 1, 0, 32'h10, 0, 0, 0, 0, 1, 32'h13, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 32'h40, 0, 0, 0, 5, 32'hBAD0_BAD0, 1, 1};
    tbl[6]  = '{0, 1, 0, 32'h44, 0, 0, 0, 0, 6, 32'hBAD1, 0, 1};
    tbl[7]  = '{0, 0, 1, 0, 32'h48, 0, 0, 0, 4, 32'hCAFE_F00D, 1, 0};
    tbl[8]  = '{0, 1, 0, 32'h4C, 0, 0, 0, 0, 4, 32'h0BAD_F00D, 0, 0};
    tbl[9]  = '{0, 1, 1, 32'h50, 32'h54, 32'hA5A5_5A5A, 4'h3, 1, 3,
                32'h5555, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 2, 32'h6666, 0, 0};

    i_rst_n        = 1'b0;
    i_ibus_req     = 1'b0;
    i_ibus_addr    = '0;
    i_dbus_req     = 1'b0;
    i_dbus_addr    = '0;
    i_dbus_wdata   = '0;
    i_dbus_wr_mask = '0;
    i_dbus_wr_en   = 1'b0;
    i_mem_rdata    = '0;
    i_mem_ack      = 1'b0;
    pend_i = 1'b0;
    pend_d = 1'b0;
    ia = '0; da = '0; dw = '0; dm = '0; dwr = 1'b0;
    exp_ir = '0;
    exp_dr = '0;
    lg     = 1'b1;

    repeat (2) @(negedge clk);
    check_zero("reset");
    i_rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) do_reset(1'b0);
      if (tbl[i].ri) raise_i(tbl[i].ia);
      if (tbl[i].rd) raise_d(tbl[i].da, tbl[i].dw, tbl[i].dm, tbl[i].dwr);
      run_txn(tbl[i].exp_d, tbl[i].exp_err, tbl[i].lat, tbl[i].mrd, 1'b0);
    end

    // Reset in the middle of a store, with a fetch waiting behind it
    raise_d(32'h500, 32'h1234_5678, 4'hF, 1'b1);
    @(negedge clk);
    check("pre_rst_mem_req", 32'(o_mem_req), 32'd1);
    check("pre_rst_wr_en", 32'(o_mem_wr_en), 32'd1);
    @(negedge clk);
    raise_i(32'h600);
    do_reset(1'b1);
    run_txn(1'b0, 1'b0, 1, 32'h77, 1'b0);
    run_txn(1'b1, 1'b0, 2, 32'h88, 1'b0);

    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 39) == 0) do_reset(1'b0);
      if (!pend_i && !pend_d && $urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) idle_cycle();
      if ($urandom_range(0, 1) == 1) raise_i($urandom);
      if ($urandom_range(0, 1) == 1)
        raise_d($urandom, $urandom, 4'($urandom), 1'($urandom));
      if (!pend_i && !pend_d) raise_i($urandom);
      rexp_d = (pend_i && pend_d) ? !lg : pend_d;
      rlat   = int'($urandom_range(1, T + 2));
      run_txn(rexp_d, rlat > T, rlat, $urandom, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
